// File: rtl/tomasulo_issue_if.sv
// Shared Tomasulo issue types and the bundle between the issue stage and its neighbours
// (instruction FIFO, register file/status, RS array, LSU, CDB).
package tomasulo_pkg;
  localparam int NUM_ALU_RS   = 3;
  localparam int NUM_SHIFT_RS = 2;
  localparam int NUM_RS       = NUM_ALU_RS + NUM_SHIFT_RS;

  typedef logic [3:0] rs_tag_t;
  localparam rs_tag_t NO_VAL = 4'd0;

  typedef struct packed {
    rs_tag_t     tag;
    logic [31:0] val;
  } cdb_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_SLT  = 3'd2,
    OP_SLTU = 3'd3,
    OP_XOR  = 3'd4,
    OP_OR   = 3'd5,
    OP_AND  = 3'd6
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_op_t;
endpackage

interface tomasulo_issue_if;
  import tomasulo_pkg::*;

  cdb_t              cdb_i;
  logic [31:0]       iq_data_i;
  logic              iq_empty_i;
  logic              iq_read_o;
  logic [4:0]        reg_rd_addr1_o, reg_rd_addr2_o;
  logic [31:0]       reg_rd_data1_i, reg_rd_data2_i;
  logic [4:0]        reg_tag_addr1_o, reg_tag_addr2_o;
  rs_tag_t           reg_tag1_rd_i, reg_tag2_rd_i;
  logic [4:0]        reg_tag_wr_addr_o;
  rs_tag_t           reg_wr_tag_o;
  logic              reg_tag_wr_en_o;
  logic [NUM_RS-1:0] busy_bus_i;
  logic [NUM_RS-1:0] rs_write_en_o;
  logic [31:0]       rs_value1_o, rs_value2_o;
  rs_tag_t           rs_tag1_o, rs_tag2_o;
  alu_op_t           alu_op_type_o;
  shift_op_t         shift_op_type_o;
  logic              load_o, write_o;
  rs_tag_t           addr_tag_o;
  logic [31:0]       addr_o, offset_o;
  rs_tag_t           data_st_tag_o;
  logic [31:0]       data_st_o;
  rs_tag_t           tag_ld_i;

  modport slave (
    input  cdb_i, iq_data_i, iq_empty_i, reg_rd_data1_i, reg_rd_data2_i,
           reg_tag1_rd_i, reg_tag2_rd_i, busy_bus_i, tag_ld_i,
    output iq_read_o, reg_rd_addr1_o, reg_rd_addr2_o, reg_tag_addr1_o, reg_tag_addr2_o,
           reg_tag_wr_addr_o, reg_wr_tag_o, reg_tag_wr_en_o, rs_write_en_o,
           rs_value1_o, rs_value2_o, rs_tag1_o, rs_tag2_o, alu_op_type_o, shift_op_type_o,
           load_o, write_o, addr_tag_o, addr_o, offset_o, data_st_tag_o, data_st_o
  );

  modport master (
    output cdb_i, iq_data_i, iq_empty_i, reg_rd_data1_i, reg_rd_data2_i,
           reg_tag1_rd_i, reg_tag2_rd_i, busy_bus_i, tag_ld_i,
    input  iq_read_o, reg_rd_addr1_o, reg_rd_addr2_o, reg_tag_addr1_o, reg_tag_addr2_o,
           reg_tag_wr_addr_o, reg_wr_tag_o, reg_tag_wr_en_o, rs_write_en_o,
           rs_value1_o, rs_value2_o, rs_tag1_o, rs_tag2_o, alu_op_type_o, shift_op_type_o,
           load_o, write_o, addr_tag_o, addr_o, offset_o, data_st_tag_o, data_st_o
  );
endinterface

// File: rtl/tomasulo_issue.sv
// Single-issue Tomasulo dispatch for RV32I ALU/shift/load/store: decodes the FIFO head,
// resolves operands (with same-cycle CDB bypass), allocates a station/LSU slot and renames rd.
module tomasulo_issue
  import tomasulo_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  tomasulo_issue_if.slave   bus
);

  typedef struct packed {
    rs_tag_t     tag;
    logic [31:0] val;
  } operand_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // A CDB hit beats the stale status tag; x0 is always a ready zero.
  function automatic operand_t resolve(input logic [4:0] addr, input rs_tag_t st,
                                       input logic [31:0] rf, input cdb_t cdb);
    operand_t o;
    if (addr == 5'd0) begin
      o.tag = NO_VAL;
      o.val = 32'd0;
    end else if (st == NO_VAL) begin
      o.tag = NO_VAL;
      o.val = rf;
    end else if (st == cdb.tag) begin
      o.tag = NO_VAL;
      o.val = cdb.val;
    end else begin
      o.tag = st;
      o.val = 32'd0;
    end
    return o;
  endfunction

  logic [31:0]       w_instr;
  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [4:0]        w_rd, w_rs1, w_rs2;
  logic [31:0]       w_imm_i, w_imm_s;
  logic              w_is_shift;
  operand_t          w_op1, w_op2;
  logic              w_alu_free, w_sh_free;
  logic [2:0]        w_alu_idx, w_sh_idx;
  logic              w_iq_read, w_tag_wr_en, w_load, w_write;
  logic [NUM_RS-1:0] w_rs_write_en;
  rs_tag_t           w_wr_tag;
  logic [31:0]       w_value2;
  rs_tag_t           w_tag2;
  alu_op_t           w_alu_op;
  shift_op_t         w_shift_op;
  logic              w_active;

  assign w_instr    = bus.iq_data_i;
  assign w_opcode   = w_instr[6:0];
  assign w_rd       = w_instr[11:7];
  assign w_funct3   = w_instr[14:12];
  assign w_rs1      = w_instr[19:15];
  assign w_rs2      = w_instr[24:20];
  assign w_imm_i    = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s    = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
  assign w_active   = !reset_i && !bus.iq_empty_i;

  assign w_op1 = resolve(w_rs1, bus.reg_tag1_rd_i, bus.reg_rd_data1_i, bus.cdb_i);
  assign w_op2 = resolve(w_rs2, bus.reg_tag2_rd_i, bus.reg_rd_data2_i, bus.cdb_i);

  // Lowest free station in each class range (descending scan so the lowest index wins).
  always_comb begin
    w_alu_free = 1'b0;
    w_alu_idx  = 3'd0;
    w_sh_free  = 1'b0;
    w_sh_idx   = 3'd0;
    for (int i = NUM_ALU_RS - 1; i >= 0; i--) begin
      if (!bus.busy_bus_i[i]) begin
        w_alu_free = 1'b1;
        w_alu_idx  = 3'(i);
      end else begin
        w_alu_free = w_alu_free;
      end
    end
    for (int i = NUM_RS - 1; i >= NUM_ALU_RS; i--) begin
      if (!bus.busy_bus_i[i]) begin
        w_sh_free = 1'b1;
        w_sh_idx  = 3'(i);
      end else begin
        w_sh_free = w_sh_free;
      end
    end
  end

  // Operation select and second operand (immediate forms bypass rs2).
  always_comb begin
    case (w_funct3)
      3'b000:  w_alu_op = (w_opcode == OPC_OP && w_instr[30]) ? OP_SUB : OP_ADD;
      3'b010:  w_alu_op = OP_SLT;
      3'b011:  w_alu_op = OP_SLTU;
      3'b100:  w_alu_op = OP_XOR;
      3'b110:  w_alu_op = OP_OR;
      3'b111:  w_alu_op = OP_AND;
      default: w_alu_op = OP_ADD;
    endcase
    if (w_funct3 == 3'b001) begin
      w_shift_op = SH_SLL;
    end else if (w_instr[30]) begin
      w_shift_op = SH_SRA;
    end else begin
      w_shift_op = SH_SRL;
    end
    if (w_opcode == OPC_OP_IMM) begin
      w_tag2   = NO_VAL;
      w_value2 = w_is_shift ? {27'd0, w_instr[24:20]} : w_imm_i;
    end else begin
      w_tag2   = w_op2.tag;
      w_value2 = w_op2.val;
    end
  end

  // Issue / stall decision, station strobe and rd rename.
  always_comb begin
    w_iq_read     = 1'b0;
    w_rs_write_en = '0;
    w_tag_wr_en   = 1'b0;
    w_wr_tag      = NO_VAL;
    w_load        = 1'b0;
    w_write       = 1'b0;
    if (w_active) begin
      case (w_opcode)
        OPC_OP_IMM, OPC_OP: begin
          if (w_is_shift && w_sh_free) begin
            w_iq_read     = 1'b1;
            w_rs_write_en = NUM_RS'(1) << w_sh_idx;
            w_wr_tag      = rs_tag_t'({1'b0, w_sh_idx} + 4'd1);
            w_tag_wr_en   = (w_rd != 5'd0);
          end else if (!w_is_shift && w_alu_free) begin
            w_iq_read     = 1'b1;
            w_rs_write_en = NUM_RS'(1) << w_alu_idx;
            w_wr_tag      = rs_tag_t'({1'b0, w_alu_idx} + 4'd1);
            w_tag_wr_en   = (w_rd != 5'd0);
          end else begin
            w_iq_read = 1'b0;
          end
        end
        OPC_LOAD: begin
          if (bus.tag_ld_i != NO_VAL) begin
            w_iq_read   = 1'b1;
            w_load      = 1'b1;
            w_wr_tag    = bus.tag_ld_i;
            w_tag_wr_en = (w_rd != 5'd0);
          end else begin
            w_iq_read = 1'b0;
          end
        end
        OPC_STORE: begin
          if (bus.tag_ld_i != NO_VAL) begin
            w_iq_read = 1'b1;
            w_write   = 1'b1;
          end else begin
            w_iq_read = 1'b0;
          end
        end
        default: w_iq_read = 1'b1;
      endcase
    end else begin
      w_iq_read = 1'b0;
    end
  end

  assign bus.iq_read_o         = w_iq_read;
  assign bus.reg_rd_addr1_o    = w_rs1;
  assign bus.reg_rd_addr2_o    = w_rs2;
  assign bus.reg_tag_addr1_o   = w_rs1;
  assign bus.reg_tag_addr2_o   = w_rs2;
  assign bus.reg_tag_wr_addr_o = w_rd;
  assign bus.reg_wr_tag_o      = w_wr_tag;
  assign bus.reg_tag_wr_en_o   = w_tag_wr_en;
  assign bus.rs_write_en_o     = w_rs_write_en;
  assign bus.rs_value1_o       = w_op1.val;
  assign bus.rs_tag1_o         = w_op1.tag;
  assign bus.rs_value2_o       = w_value2;
  assign bus.rs_tag2_o         = w_tag2;
  assign bus.alu_op_type_o     = w_alu_op;
  assign bus.shift_op_type_o   = w_shift_op;
  assign bus.load_o            = w_load;
  assign bus.write_o           = w_write;
  assign bus.addr_tag_o        = w_op1.tag;
  assign bus.addr_o            = w_op1.val;
  assign bus.offset_o          = (w_opcode == OPC_STORE) ? w_imm_s : w_imm_i;
  assign bus.data_st_tag_o     = w_op2.tag;
  assign bus.data_st_o         = w_op2.val;

  logic w_unused_clk;
  assign w_unused_clk = clk_i;

endmodule

// File: tb/tb_tomasulo_issue.sv
// Directed bench for tomasulo_issue: hand-encoded RV32I instructions with hand-computed outputs.
module tb_tomasulo_issue;
  import tomasulo_pkg::*;

  localparam rs_tag_t ALU_1 = 4'd1;
  localparam rs_tag_t ALU_2 = 4'd2;
  localparam rs_tag_t ALU_3 = 4'd3;
  localparam rs_tag_t LS_1  = 4'd6;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  tomasulo_issue_if bus ();

  tomasulo_issue dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.cdb_i          = '{tag: NO_VAL, val: 32'd0};
    bus.iq_data_i      = 32'h00500093;
    bus.iq_empty_i     = 1'b0;
    bus.reg_rd_data1_i = 32'd0;
    bus.reg_rd_data2_i = 32'd0;
    bus.reg_tag1_rd_i  = NO_VAL;
    bus.reg_tag2_rd_i  = NO_VAL;
    bus.busy_bus_i     = 5'b00000;
    bus.tag_ld_i       = LS_1;

    // reset held for 3 cycles with a valid head
    repeat (3) @(posedge clk);
    #1;
    chk("rst_iq_read", 32'(bus.iq_read_o), 32'd0);
    chk("rst_rs_en", 32'(bus.rs_write_en_o), 32'd0);
    chk("rst_tag_wr_en", 32'(bus.reg_tag_wr_en_o), 32'd0);
    chk("rst_ld_st", {30'd0, bus.load_o, bus.write_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.iq_empty_i = 1'b1;
    #1;
    chk("empty_iq_read", 32'(bus.iq_read_o), 32'd0);
    chk("empty_rs_en", 32'(bus.rs_write_en_o), 32'd0);

    // addi x1,x0,5
    @(negedge clk);
    bus.iq_empty_i     = 1'b0;
    bus.iq_data_i      = 32'h00500093;
    bus.reg_rd_data1_i = 32'hDEADBEEF;
    #1;
    chk("addi_rs_en", 32'(bus.rs_write_en_o), 32'h1);
    chk("addi_iq_read", 32'(bus.iq_read_o), 32'd1);
    chk("addi_v1", bus.rs_value1_o, 32'd0);
    chk("addi_t1", 32'(bus.rs_tag1_o), 32'(NO_VAL));
    chk("addi_v2", bus.rs_value2_o, 32'd5);
    chk("addi_t2", 32'(bus.rs_tag2_o), 32'(NO_VAL));
    chk("addi_ren", {bus.reg_tag_wr_en_o, 3'd0, bus.reg_tag_wr_addr_o, 4'd0, bus.reg_wr_tag_o},
        {1'b1, 3'd0, 5'd1, 4'd0, ALU_1});
    chk("addi_op", 32'(bus.alu_op_type_o), 32'(OP_ADD));

    // add x2,x1,x1 while x1 is pending on ALU_1
    @(negedge clk);
    bus.iq_data_i     = 32'h00108133;
    bus.busy_bus_i    = 5'b00001;
    bus.reg_tag1_rd_i = ALU_1;
    bus.reg_tag2_rd_i = ALU_1;
    #1;
    chk("add_addr", {bus.reg_rd_addr1_o, bus.reg_rd_addr2_o, bus.reg_tag_addr1_o, bus.reg_tag_addr2_o},
        {5'd1, 5'd1, 5'd1, 5'd1});
    chk("add_rs_en", 32'(bus.rs_write_en_o), 32'h2);
    chk("add_tags", {bus.rs_tag1_o, bus.rs_tag2_o}, {ALU_1, ALU_1});
    chk("add_ren", {bus.reg_tag_wr_en_o, 3'd0, bus.reg_tag_wr_addr_o, 4'd0, bus.reg_wr_tag_o},
        {1'b1, 3'd0, 5'd2, 4'd0, ALU_2});

    // sub x4,x3,x0 with x3 on ALU_3 broadcasting -5 this cycle
    @(negedge clk);
    bus.iq_data_i     = 32'h40018233;
    bus.busy_bus_i    = 5'b00100;
    bus.reg_tag1_rd_i = ALU_3;
    bus.reg_tag2_rd_i = NO_VAL;
    bus.cdb_i         = '{tag: ALU_3, val: 32'hFFFFFFFB};
    #1;
    chk("sub_v1", bus.rs_value1_o, 32'hFFFFFFFB);
    chk("sub_t1", 32'(bus.rs_tag1_o), 32'(NO_VAL));
    chk("sub_v2", bus.rs_value2_o, 32'd0);
    chk("sub_op", 32'(bus.alu_op_type_o), 32'(OP_SUB));
    chk("sub_rs_en", 32'(bus.rs_write_en_o), 32'h1);

    // all ALU stations busy: add stalls, then frees up
    @(negedge clk);
    bus.cdb_i         = '{tag: NO_VAL, val: 32'd0};
    bus.iq_data_i     = 32'h00108133;
    bus.busy_bus_i    = 5'b00111;
    bus.reg_tag1_rd_i = NO_VAL;
    bus.reg_tag2_rd_i = NO_VAL;
    #1;
    chk("full_iq_read", 32'(bus.iq_read_o), 32'd0);
    chk("full_en", {bus.rs_write_en_o, bus.reg_tag_wr_en_o}, 32'd0);
    bus.busy_bus_i = 5'b00000;
    #1;
    chk("free_rs_en", 32'(bus.rs_write_en_o), 32'h1);
    chk("free_iq_read", 32'(bus.iq_read_o), 32'd1);

    // nop occupies a station but renames nothing
    @(negedge clk);
    bus.iq_data_i = 32'h00000013;
    #1;
    chk("nop_rs_en", 32'(bus.rs_write_en_o), 32'h1);
    chk("nop_tag_wr_en", 32'(bus.reg_tag_wr_en_o), 32'd0);

    // lw x5,8(x1)
    @(negedge clk);
    bus.iq_data_i      = 32'h0080A283;
    bus.reg_rd_data1_i = 32'h00000100;
    #1;
    chk("lw_load", {30'd0, bus.load_o, bus.write_o}, 32'h2);
    chk("lw_offset", bus.offset_o, 32'd8);
    chk("lw_addr", bus.addr_o, 32'h00000100);
    chk("lw_rs_en", 32'(bus.rs_write_en_o), 32'd0);
    chk("lw_ren", {bus.reg_tag_wr_en_o, 3'd0, bus.reg_tag_wr_addr_o, 4'd0, bus.reg_wr_tag_o},
        {1'b1, 3'd0, 5'd5, 4'd0, LS_1});
    bus.tag_ld_i = NO_VAL;
    #1;
    chk("lw_full_iq_read", 32'(bus.iq_read_o), 32'd0);
    chk("lw_full_load", 32'(bus.load_o), 32'd0);

    // sw x2,-4(x1) with x2 pending on ALU_2
    @(negedge clk);
    bus.tag_ld_i      = LS_1;
    bus.iq_data_i     = 32'hFE20AE23;
    bus.reg_tag2_rd_i = ALU_2;
    #1;
    chk("sw_write", {30'd0, bus.load_o, bus.write_o}, 32'h1);
    chk("sw_offset", bus.offset_o, 32'hFFFFFFFC);
    chk("sw_data_tag", 32'(bus.data_st_tag_o), 32'(ALU_2));
    chk("sw_no_rename", 32'(bus.reg_tag_wr_en_o), 32'd0);

    // srai x6,x5,2 with x5 pending on LS_1
    @(negedge clk);
    bus.iq_data_i     = 32'h4022D313;
    bus.reg_tag1_rd_i = LS_1;
    bus.reg_tag2_rd_i = NO_VAL;
    #1;
    chk("srai_rs_en", 32'(bus.rs_write_en_o), 32'h8);
    chk("srai_op", 32'(bus.shift_op_type_o), 32'(SH_SRA));
    chk("srai_v2", bus.rs_value2_o, 32'd2);
    chk("srai_t1", 32'(bus.rs_tag1_o), 32'(LS_1));
    chk("srai_ren", {bus.reg_tag_wr_en_o, 3'd0, bus.reg_tag_wr_addr_o, 4'd0, bus.reg_wr_tag_o},
        {1'b1, 3'd0, 5'd6, 4'd0, 4'd4});

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
